// File: rtl/traffic_injector_param.sv
// Parametrised PE traffic injector. Builds header-flit packets with a
// selectable destination pattern and an LFSR-driven inter-packet gap, then
// offers them to the router Local port over the ReqDnStr/GntDnStr/DnStrFull
// handshake. A non-zero max_pkts stops injection once that many packets
// have been granted. All randomness comes from one free-running LFSR, so a
// given seed always reproduces the same traffic.
// The LFSR is 16 bits wide, so GAP_W and 2*DIM must not exceed 16.
module traffic_injector_param #(
  parameter int unsigned      DIM       = 4,
  parameter int unsigned      ID_W      = 10,
  parameter int unsigned      MID_W     = 6,
  parameter logic [MID_W-1:0] MODULE_ID = 6'b000_000,
  parameter logic [DIM-1:0]   SRC_X     = 4'b0000,
  parameter logic [DIM-1:0]   SRC_Y     = 4'b0000,
  parameter logic [DIM-1:0]   FIX_X     = 4'b1010,
  parameter logic [DIM-1:0]   FIX_Y     = 4'b0001,
  parameter int unsigned      GAP_W     = 4,
  parameter logic [15:0]      LFSR_SEED = 16'hACE1,
  localparam int unsigned     DATA_W    = 4*DIM + ID_W + MID_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [GAP_W-1:0]  gap_mask,
  input  logic [ID_W-1:0]   max_pkts,
  input  logic              DnStrFull,
  input  logic              GntDnStr,
  output logic              ReqDnStr,
  output logic [DATA_W-1:0] PacketOut,
  output logic [31:0]       send_time,
  output logic [ID_W-1:0]   sent_count,
  output logic              done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GAP      = 2'd1;
  localparam logic [1:0] ST_REQ      = 2'd2;
  localparam logic [1:0] ST_WAIT_GNT = 2'd3;

  localparam logic [1:0] MODE_FIXED     = 2'd0;
  localparam logic [1:0] MODE_UNIFORM   = 2'd1;
  localparam logic [1:0] MODE_TRANSPOSE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]  delay_q, delay_d;
  logic [ID_W-1:0]   pkt_id_q, pkt_id_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] pkt_out_q, pkt_out_d;
  logic [31:0]       send_time_q, send_time_d;
  logic [ID_W-1:0]   sent_q, sent_d;
  logic              done_q, done_d;

  logic [DIM-1:0]    rand_x, rand_y;
  logic [DIM-1:0]    dst_x, dst_y;
  logic [ID_W-1:0]   next_id;
  logic [ID_W-1:0]   next_sent;
  logic              lfsr_fb;

  // Free-running timebase and LFSR; both advance every non-reset cycle
  always_comb begin
    lfsr_fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d        = {lfsr_q[14:0], lfsr_fb};
    cycle_count_d = cycle_count_q + 32'd1;
  end

  // Destination of the packet about to be staged, chosen by mode
  always_comb begin
    rand_x = lfsr_q[DIM-1:0];
    rand_y = lfsr_q[2*DIM-1:DIM];
    dst_x  = FIX_X;
    dst_y  = FIX_Y;
    case (mode)
      MODE_FIXED: begin
        dst_x = FIX_X;
        dst_y = FIX_Y;
      end
      MODE_UNIFORM: begin
        if ((rand_x == SRC_X) && (rand_y == SRC_Y)) begin
          dst_x = ~SRC_X;
          dst_y = ~SRC_Y;
        end else begin
          dst_x = rand_x;
          dst_y = rand_y;
        end
      end
      MODE_TRANSPOSE: begin
        dst_x = SRC_Y;
        dst_y = SRC_X;
      end
      default: begin
        dst_x = ~SRC_X;
        dst_y = ~SRC_Y;
      end
    endcase
  end

  // Packet sequencing: pick a gap, wait it out, stage, request, await grant
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    delay_d     = delay_q;
    pkt_id_d    = pkt_id_q;
    stage_d     = stage_q;
    req_d       = req_q;
    pkt_out_d   = pkt_out_q;
    send_time_d = send_time_q;
    sent_d      = sent_q;
    done_d      = done_q;
    next_id     = pkt_id_q + ID_W'(1);
    next_sent   = sent_q + ID_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (enable && !done_q) begin
          delay_d   = lfsr_q[GAP_W-1:0] & gap_mask;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == delay_q) begin
          stage_d = {dst_x, dst_y, SRC_X, SRC_Y, next_id, MODULE_ID};
          state_d = ST_REQ;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_REQ: begin
        if (!DnStrFull) begin
          req_d       = 1'b1;
          pkt_out_d   = stage_q;
          send_time_d = cycle_count_q;
          state_d     = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        if (GntDnStr) begin
          req_d    = 1'b0;
          pkt_id_d = next_id;
          sent_d   = next_sent;
          if ((max_pkts != '0) && (next_sent == max_pkts)) begin
            done_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= LFSR_SEED;
      cycle_count_q <= '0;
      gap_cnt_q     <= '0;
      delay_q       <= '0;
      pkt_id_q      <= '0;
      stage_q       <= '0;
      req_q         <= 1'b0;
      pkt_out_q     <= '0;
      send_time_q   <= '0;
      sent_q        <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      cycle_count_q <= cycle_count_d;
      gap_cnt_q     <= gap_cnt_d;
      delay_q       <= delay_d;
      pkt_id_q      <= pkt_id_d;
      stage_q       <= stage_d;
      req_q         <= req_d;
      pkt_out_q     <= pkt_out_d;
      send_time_q   <= send_time_d;
      sent_q        <= sent_d;
      done_q        <= done_d;
    end
  end

  assign ReqDnStr   = req_q;
  assign PacketOut  = pkt_out_q;
  assign send_time  = send_time_q;
  assign sent_count = sent_q;
  assign done       = done_q;

endmodule

// File: tb/tb_traffic_injector_param.sv
// Bench for traffic_injector_param. Two instances (source 0,0 and source
// 2,5) share one stimulus stream; a transaction-level reference model
// predicts every output each cycle, and directed phases pin the model with
// hand-computed packet values.
module tb_traffic_injector_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  gap_mask = 4'd0;
  logic [9:0]  max_pkts = 10'd0;
  logic        full = 1'b0;
  logic        gnt = 1'b0;

  logic        req_a, req_b, done_a, done_b;
  logic [31:0] pkt_a, pkt_b, st_a, st_b;
  logic [9:0]  sent_a, sent_b;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;
  int tb_cyc = 0;

  logic        prev_req = 1'b0;
  bit          have_grant = 1'b0;
  int          last_grant = 0;
  int          n_grants = 0;
  logic [31:0] rise_a_q[$];
  logic [31:0] rise_b_q[$];

  // Reference model state
  logic [15:0] m_lfsr;
  logic [31:0] m_cyc;
  int          m_k;
  bit          m_busy, m_staged;
  int          m_gap_end;
  logic [31:0] m_stage_a, m_stage_b;
  logic        m_req;
  logic [31:0] m_pkt_a, m_pkt_b, m_send;
  logic [9:0]  m_id, m_sent;
  logic        m_done;

  always #5 clk = ~clk;

  traffic_injector_param u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .gap_mask(gap_mask), .max_pkts(max_pkts), .DnStrFull(full),
    .GntDnStr(gnt), .ReqDnStr(req_a), .PacketOut(pkt_a),
    .send_time(st_a), .sent_count(sent_a), .done(done_a)
  );

  traffic_injector_param #(.SRC_X(4'h2), .SRC_Y(4'h5)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .gap_mask(gap_mask), .max_pkts(max_pkts), .DnStrFull(full),
    .GntDnStr(gnt), .ReqDnStr(req_b), .PacketOut(pkt_b),
    .send_time(st_b), .sent_count(sent_b), .done(done_b)
  );

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    int fb;
    fb = ((int'(v) >> 15) ^ (int'(v) >> 13) ^ (int'(v) >> 12) ^ (int'(v) >> 10)) & 1;
    return 16'(((int'(v) << 1) | fb) & 16'hFFFF);
  endfunction

  function automatic logic [31:0] makePkt(input logic [1:0] md, input logic [15:0] rnd,
                                          input int sx, input int sy, input logic [9:0] id);
    int dx, dy;
    case (md)
      2'd0: begin dx = 10; dy = 1; end
      2'd1: begin
        dx = int'(rnd) % 16;
        dy = (int'(rnd) / 16) % 16;
        if (dx == sx && dy == sy) begin dx = 15 - sx; dy = 15 - sy; end
      end
      2'd2: begin dx = sy; dy = sx; end
      default: begin dx = 15 - sx; dy = 15 - sy; end
    endcase
    return 32'((dx << 28) + (dy << 24) + (sx << 20) + (sy << 16) + (int'(id) << 6));
  endfunction

  // Transaction-level model: a packet starts, waits its gap, is offered
  // once the port is not full, and retires on the first grant after that
  always @(posedge clk) begin
    if (reset) begin
      m_lfsr <= 16'hACE1; m_cyc <= '0; m_k <= 0;
      m_busy <= 1'b0; m_staged <= 1'b0; m_gap_end <= 0;
      m_stage_a <= '0; m_stage_b <= '0;
      m_req <= 1'b0; m_pkt_a <= '0; m_pkt_b <= '0; m_send <= '0;
      m_id <= '0; m_sent <= '0; m_done <= 1'b0;
    end else begin
      if (!m_busy) begin
        if (enable && !m_done) begin
          m_busy    <= 1'b1;
          m_staged  <= 1'b0;
          m_gap_end <= m_k + 1 + int'(m_lfsr[3:0] & gap_mask);
        end
      end else if (!m_staged) begin
        if (m_k == m_gap_end) begin
          m_stage_a <= makePkt(mode, m_lfsr, 0, 0, m_id + 10'd1);
          m_stage_b <= makePkt(mode, m_lfsr, 2, 5, m_id + 10'd1);
          m_staged  <= 1'b1;
        end
      end else if (!m_req) begin
        if (!full) begin
          m_req   <= 1'b1;
          m_pkt_a <= m_stage_a;
          m_pkt_b <= m_stage_b;
          m_send  <= m_cyc;
        end
      end else if (gnt) begin
        m_req  <= 1'b0;
        m_busy <= 1'b0;
        m_id   <= m_id + 10'd1;
        m_sent <= m_sent + 10'd1;
        if (max_pkts != 10'd0 && (m_sent + 10'd1) == max_pkts) m_done <= 1'b1;
      end
      m_lfsr <= lfsrStep(m_lfsr);
      m_cyc  <= m_cyc + 32'd1;
      m_k    <= m_k + 1;
    end
  end

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, both instances must match the model
  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("req_a", 32'(req_a), 32'(m_req));
      checkOutput("req_b", 32'(req_b), 32'(m_req));
      checkOutput("pkt_a", pkt_a, m_pkt_a);
      checkOutput("pkt_b", pkt_b, m_pkt_b);
      checkOutput("send_time_a", st_a, m_send);
      checkOutput("send_time_b", st_b, m_send);
      checkOutput("sent_a", 32'(sent_a), 32'(m_sent));
      checkOutput("sent_b", 32'(sent_b), 32'(m_sent));
      checkOutput("done_a", 32'(done_a), 32'(m_done));
      checkOutput("done_b", 32'(done_b), 32'(m_done));
    end
  end

  task automatic applyStimulus(input logic en, input logic [1:0] md, input logic [3:0] gm,
                               input logic [9:0] mx, input logic fl);
    enable = en; mode = md; gap_mask = gm; max_pkts = mx; full = fl;
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; gnt = 1'b0; full = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rise_a_q.delete(); rise_b_q.delete();
    prev_req = 1'b0; have_grant = 1'b0; n_grants = 0;
  endtask

  // Advance n cycles, recording request rises and grants
  task automatic runCycles(input int n, input bit auto_gnt, input bit chk_gap,
                           input int gap_max, input bit chk_src);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (req_a && !prev_req) begin
        rise_a_q.push_back(pkt_a);
        rise_b_q.push_back(pkt_b);
        if (chk_gap && have_grant) begin
          g = tb_cyc - last_grant - 3;
          checkOutput("gap_range", 32'(g >= 0 && g <= gap_max), 32'd1);
        end
        if (chk_src) begin
          checkOutput("dst_ne_src_a", 32'(pkt_a[31:24] != 8'h00), 32'd1);
          checkOutput("dst_ne_src_b", 32'(pkt_b[31:24] != 8'h25), 32'd1);
        end
      end
      if (prev_req && !req_a && !reset) begin
        last_grant = tb_cyc;
        have_grant = 1'b1;
        n_grants++;
      end
      prev_req = req_a;
      if (auto_gnt) gnt = req_a;
    end
  endtask

  initial begin
    logic [31:0] p;
    logic [7:0]  dst;
    bit          seen;

    @(negedge clk);
    cmp_on = 1'b1;
    resetDut();
    checkOutput("rst_req", 32'(req_a), 32'd0);
    checkOutput("rst_pkt", pkt_a, 32'd0);
    checkOutput("rst_send_time", st_a, 32'd0);
    checkOutput("rst_sent", 32'(sent_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);

    // Fixed mode, zero gap, budget of three
    applyStimulus(1'b1, 2'd0, 4'd0, 10'd3, 1'b0);
    runCycles(40, 1'b1, 1'b1, 0, 1'b0);
    checkOutput("fixed_count", 32'(rise_a_q.size()), 32'd3);
    if (rise_a_q.size() == 3) begin
      checkOutput("fixed_pkt1", rise_a_q[0], 32'hA1000040);
      checkOutput("fixed_pkt2", rise_a_q[1], 32'hA1000080);
      checkOutput("fixed_pkt3", rise_a_q[2], 32'hA10000C0);
    end
    checkOutput("fixed_done", 32'(done_a), 32'd1);
    checkOutput("fixed_sent", 32'(sent_a), 32'd3);

    // Transpose and bit-complement
    resetDut();
    applyStimulus(1'b1, 2'd2, 4'd0, 10'd1, 1'b0);
    runCycles(15, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("transpose_count", 32'(rise_b_q.size()), 32'd1);
    if (rise_b_q.size() >= 1) begin
      p = rise_b_q[0]; dst = p[31:24];
      checkOutput("transpose_dst_b", 32'(dst), 32'h52);
      p = rise_a_q[0]; dst = p[31:24];
      checkOutput("transpose_dst_a", 32'(dst), 32'h00);
    end
    resetDut();
    applyStimulus(1'b1, 2'd3, 4'd0, 10'd1, 1'b0);
    runCycles(15, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("complement_count", 32'(rise_b_q.size()), 32'd1);
    if (rise_b_q.size() >= 1) begin
      p = rise_b_q[0]; dst = p[31:24];
      checkOutput("complement_dst_b", 32'(dst), 32'hDA);
      p = rise_a_q[0]; dst = p[31:24];
      checkOutput("complement_dst_a", 32'(dst), 32'hFF);
    end

    // Downstream full for ten cycles while a packet waits to be offered
    resetDut();
    applyStimulus(1'b1, 2'd0, 4'd0, 10'd0, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("full_holds_req", 32'(req_a), 32'd0);
    end
    full = 1'b0;
    @(negedge clk);
    checkOutput("full_release_req", 32'(req_a), 32'd1);
    checkOutput("full_release_time", st_a, 32'd12);

    // Grant withheld for twenty cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("hold_req", 32'(req_a), 32'd1);
      checkOutput("hold_pkt", pkt_a, 32'hA1000040);
    end
    gnt = 1'b1;
    @(negedge clk);
    checkOutput("granted_req", 32'(req_a), 32'd0);
    checkOutput("granted_sent", 32'(sent_a), 32'd1);
    checkOutput("granted_pkt_held", pkt_a, 32'hA1000040);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle_grant_ignored", 32'(sent_a), 32'd1);
    gnt = 1'b0; enable = 1'b1; gap_mask = 4'hF;
    @(negedge clk);
    gnt = 1'b1; enable = 1'b0;
    @(negedge clk);
    gnt = 1'b0;
    checkOutput("gap_grant_ignored", 32'(sent_a), 32'd1);
    prev_req = req_a;
    runCycles(25, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("inflight_completes", 32'(sent_a), 32'd2);
    checkOutput("disabled_no_req", 32'(req_a), 32'd0);

    // Reset landing on the same edge as a grant
    resetDut();
    applyStimulus(1'b1, 2'd0, 4'd0, 10'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = req_a;
    end
    checkOutput("req_before_reset", 32'(seen), 32'd1);
    reset = 1'b1; gnt = 1'b1;
    @(negedge clk);
    checkOutput("rst_hs_req", 32'(req_a), 32'd0);
    checkOutput("rst_hs_pkt", pkt_a, 32'd0);
    checkOutput("rst_hs_time", st_a, 32'd0);
    checkOutput("rst_hs_sent", 32'(sent_a), 32'd0);
    checkOutput("rst_hs_done", 32'(done_a), 32'd0);
    reset = 1'b0; gnt = 1'b0; enable = 1'b0;

    // Uniform random destinations, 1000 packets, then a shorter rerun
    for (int run = 0; run < 2; run++) begin
      resetDut();
      applyStimulus(1'b1, 2'd1, 4'hF, 10'd0, 1'b0);
      for (int c = 0; c < 30000 && n_grants < ((run == 0) ? 1000 : 200); c++) begin
        runCycles(1, 1'b1, 1'b1, 15, 1'b1);
      end
      checkOutput("uniform_grants", 32'(n_grants), (run == 0) ? 32'd1000 : 32'd200);
      checkOutput("uniform_sent", 32'(sent_a), (run == 0) ? 32'd1000 : 32'd200);
    end

    // Fully random traffic against the model
    resetDut();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 399) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) begin
        mode     = 2'($urandom);
        gap_mask = 4'($urandom);
        max_pkts = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 40));
      end
      full = ($urandom_range(0, 3) == 0);
      gnt  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
